// File: rtl/data_mem_responder.sv
// Slave end of the hart data-memory port: word RAM behind a wait-state FSM,
// with RV32 lane steering, load extension and access-error detection.
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_DM_Addr,
    input  logic [31:0] i_DM_WriteData,
    input  logic [2:0]  i_DM_f3,
    input  logic        i_DM_MemRead,
    input  logic        i_DM_Wen,
    output logic        o_DM_data_ready,
    output logic [31:0] o_DM_ReadData,
    output logic        o_DM_err
);
    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam int         AW    = DEPTH_LOG2 + 2;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    function automatic logic access_err(input logic [2:0] f3, input logic [1:0] a, input logic st);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = a[0];
            3'b010:  e = (a != 2'b00);
            3'b100:  e = st;
            3'b101:  e = st | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] sh;
        logic [15:0] h;
        logic [31:0] r;
        sh = w >> {a, 3'b000};
        h  = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'd0, sh[7:0]};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = w;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] a);
        logic [3:0]  be;
        logic [31:0] lanes;
        logic [31:0] r;
        case (f3)
            3'b000:  begin be = 4'b0001 << a;                   lanes = {4{wd[7:0]}};  end
            3'b001:  begin be = a[1] ? 4'b1100 : 4'b0011;       lanes = {2{wd[15:0]}}; end
            3'b010:  begin be = 4'b1111;                        lanes = wd;            end
            default: begin be = 4'b0000;                        lanes = wd;            end
        endcase
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? lanes[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic        ready_q, ready_d, err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_q [DEPTH];

    logic        enter_resp;
    logic        acc_err;
    logic        mem_we;
    logic [AW-1:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [2:0]  eff_f3;
    logic        eff_rd, eff_wr;
    logic [31:0] mem_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^i_DM_Addr[31:AW];

    // With zero wait states the access completes on the capture edge, so it must use the live inputs.
    always_comb begin
        if (state_q == IDLE) begin
            eff_addr  = i_DM_Addr[AW-1:0];
            eff_wdata = i_DM_WriteData;
            eff_f3    = i_DM_f3;
            eff_rd    = i_DM_MemRead;
            eff_wr    = i_DM_Wen;
        end else begin
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_f3    = f3_q;
            eff_rd    = rd_q;
            eff_wr    = wr_q;
        end
    end

    // Next-state, capture and response computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_DM_MemRead | i_DM_Wen) begin
                    addr_d  = i_DM_Addr[AW-1:0];
                    wdata_d = i_DM_WriteData;
                    f3_d    = i_DM_f3;
                    rd_d    = i_DM_MemRead;
                    wr_d    = i_DM_Wen;
                    cnt_d   = LAT;
                    if (LAT != 4'd0) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_word = mem_q[eff_addr[AW-1:2]];
        acc_err  = access_err(eff_f3, eff_addr[1:0], eff_wr);
        ready_d  = enter_resp;
        err_d    = enter_resp & acc_err;
        if (enter_resp & eff_rd & ~acc_err) begin
            rdata_d = load_ext(mem_word, eff_f3, eff_addr[1:0]);
        end else begin
            rdata_d = 32'd0;
        end
        mem_we = enter_resp & eff_wr & ~acc_err & ~i_rst;
    end

    // Control and response registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM contents survive reset; a swap reads the old word above before this commit lands.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[eff_addr[AW-1:2]] <= store_merge(mem_word, eff_wdata, eff_f3, eff_addr[1:0]);
        end
    end

    assign o_DM_data_ready = ready_q;
    assign o_DM_ReadData   = rdata_q;
    assign o_DM_err        = err_q;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the hart data-memory port: accepts load/store requests (address, write data, funct3, read/write strobes) and answers with a ready pulse plus read data.
- Holds a word-organised internal RAM and a programmable wait-state counter.
- Performs RV32 byte/half/word lane steering and load sign/zero extension.
- Sits between the hart's data port and the system bus; it is the slave end of that port.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words; word index = i_DM_Addr[DEPTH_LOG2+1:2], upper address bits ignored (aliasing).
- LATENCY, 1, wait-state cycles between request capture and the ready cycle (0..15).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_DM_Addr  in  32  byte address.
- i_DM_WriteData  in  32  store data, right-aligned.
- i_DM_f3  in  3  RV32 funct3 access size/sign.
- i_DM_MemRead  in  1  load request, level, held until ready.
- i_DM_Wen  in  1  store request, level, held until ready.
- o_DM_data_ready  out  1  one-cycle completion pulse.
- o_DM_ReadData  out  32  extended load result, valid while ready=1.
- o_DM_err  out  1  misaligned or illegal-f3 flag, valid while ready=1.

Behaviour:
- Single clock domain; i_rst is asynchronous and active-high.
- Reset forces: state IDLE; o_DM_data_ready=0; o_DM_ReadData=0; o_DM_err=0; wait counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: at an edge with MemRead|Wen=1, latch addr, wdata, f3, rd and wr, and load the counter with LATENCY. Go to WAIT if LATENCY>0, else RESP.
  - WAIT: decrement the counter each edge; at 1, go to RESP.
  - RESP: ready=1 for exactly one cycle, then IDLE.
- Ready timing: ready is high in cycle LATENCY+1 after the capture edge.
- Requests present during WAIT/RESP are ignored. Inputs are not re-sampled, and the latched copy is used throughout.
- The hart keeps its strobes high across the ready edge when the next instruction is also a memory op. IDLE in the following cycle therefore captures that as a new transaction, giving back-to-back throughput of one access per LATENCY+2 cycles.
- Read data and err are registered on the edge entering RESP. Outside RESP they return to 0.
- Load f3:
  - 000 LB: sign-extended byte at addr[1:0] lane.
  - 001 LH: sign-extended half at addr[1].
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extended.
- Store f3 byte-enables:
  - 000 SB: lane addr[1:0] gets wdata[7:0].
  - 001 SH: half addr[1] gets wdata[15:0].
  - 010 SW: all lanes.
  - Unselected lanes are unchanged.
- Store commit: RAM write occurs on the edge entering RESP.
- Error cases; each gives err=1, ready still pulses, no RAM write, ReadData=0:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - f3 in {011,110,111}, or f3 in {100,101} on a store.
- MemRead and Wen both high (atomic swap): ReadData returns the pre-write value of the addressed location using the load f3 extension rules, and the write is committed on the same edge.
- Reset asserted mid-transaction: returns to IDLE immediately; the pending store is dropped and no ready is issued. Stores already committed remain.
- Address aliasing wraps modulo 4*2^DEPTH_LOG2 bytes.

Test Plan:
- Word store then load, LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10. Each ready occurs 2 cycles after capture; LW returns 0xDEADBEEF with err=0.
- Byte lanes: SB 0x80 @0x13 into word 0x00000000, then LB @0x13 returns 0xFFFFFF80, LBU returns 0x00000080, LW @0x10 returns 0x80000000.
- Halfword: SH 0x1234 @0x22, then LH @0x22 returns 0x00001234. LH @0x21 gives err=1, ReadData=0, and a following LW @0x20 shows memory unchanged.
- Back-to-back with strobes held continuously: 3 loads with LATENCY=0 give ready pulses in cycles 1, 3 and 5, never two consecutive ready cycles.
- Swap: word @0x40=0x11111111; MemRead=Wen=1 with wdata 0x22222222 returns 0x11111111, and a subsequent LW returns 0x22222222.
- Reset in WAIT with LATENCY=3 during SW 0xAAAA5555 @0x8: ready never asserts, and a post-reset LW @0x8 returns the old value.
